// File: rtl/duc_tx_core.sv
// rtl/duc_tx_core.sv - digital upconverter: zero-order-hold interpolation, NCO mixing, saturating DAC output
// Hold register feeds a three-stage pipeline: phase index, sin/cos lookup, mix and saturate.
module duc_tx_core #(
  parameter int DATA_WIDTH = 18,
  parameter int DAC_WIDTH  = 16,
  parameter int NCO_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [7:0]            interp,
  input  logic [NCO_WIDTH-1:0]  nco_freq,
  input  logic [15:0]           nco_phase_offset,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic [DATA_WIDTH-1:0] q_data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DAC_WIDTH-1:0]  dac_data,
  output logic                  dac_valid,
  input  logic                  dac_ready,
  output logic [15:0]           underflow_count,
  output logic                  sat_flag,
  output logic                  busy
);

  localparam int PW = DATA_WIDTH + 17;
  localparam logic signed [PW-1:0] DAC_MAX = {{(PW-DAC_WIDTH+1){1'b0}}, {(DAC_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] DAC_MIN = {{(PW-DAC_WIDTH+1){1'b1}}, {(DAC_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // First quadrant of round(32767*sin(2*pi*k/256)), k = 0..64.
  function automatic logic [14:0] qsin(input logic [6:0] k);
    logic [14:0] v;
    case (k)
      7'd0:  v = 15'd0;
      7'd1:  v = 15'd804;
      7'd2:  v = 15'd1608;
      7'd3:  v = 15'd2410;
      7'd4:  v = 15'd3212;
      7'd5:  v = 15'd4011;
      7'd6:  v = 15'd4808;
      7'd7:  v = 15'd5602;
      7'd8:  v = 15'd6393;
      7'd9:  v = 15'd7179;
      7'd10: v = 15'd7962;
      7'd11: v = 15'd8739;
      7'd12: v = 15'd9512;
      7'd13: v = 15'd10278;
      7'd14: v = 15'd11039;
      7'd15: v = 15'd11793;
      7'd16: v = 15'd12539;
      7'd17: v = 15'd13279;
      7'd18: v = 15'd14010;
      7'd19: v = 15'd14732;
      7'd20: v = 15'd15446;
      7'd21: v = 15'd16151;
      7'd22: v = 15'd16846;
      7'd23: v = 15'd17530;
      7'd24: v = 15'd18204;
      7'd25: v = 15'd18868;
      7'd26: v = 15'd19519;
      7'd27: v = 15'd20159;
      7'd28: v = 15'd20787;
      7'd29: v = 15'd21403;
      7'd30: v = 15'd22005;
      7'd31: v = 15'd22594;
      7'd32: v = 15'd23170;
      7'd33: v = 15'd23731;
      7'd34: v = 15'd24279;
      7'd35: v = 15'd24811;
      7'd36: v = 15'd25329;
      7'd37: v = 15'd25832;
      7'd38: v = 15'd26319;
      7'd39: v = 15'd26790;
      7'd40: v = 15'd27245;
      7'd41: v = 15'd27683;
      7'd42: v = 15'd28105;
      7'd43: v = 15'd28510;
      7'd44: v = 15'd28898;
      7'd45: v = 15'd29268;
      7'd46: v = 15'd29621;
      7'd47: v = 15'd29956;
      7'd48: v = 15'd30273;
      7'd49: v = 15'd30571;
      7'd50: v = 15'd30852;
      7'd51: v = 15'd31113;
      7'd52: v = 15'd31356;
      7'd53: v = 15'd31580;
      7'd54: v = 15'd31785;
      7'd55: v = 15'd31971;
      7'd56: v = 15'd32137;
      7'd57: v = 15'd32285;
      7'd58: v = 15'd32412;
      7'd59: v = 15'd32521;
      7'd60: v = 15'd32609;
      7'd61: v = 15'd32678;
      7'd62: v = 15'd32728;
      7'd63: v = 15'd32757;
      7'd64: v = 15'd32767;
      default: v = 15'd0;
    endcase
    return v;
  endfunction

  // Quadrant 1/3 mirror the table index, quadrants 2/3 negate.
  function automatic logic signed [15:0] sin_lut(input logic [7:0] idx);
    logic [6:0]         k;
    logic signed [15:0] mag;
    k   = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
    mag = $signed({1'b0, qsin(k)});
    return idx[7] ? -mag : mag;
  endfunction

  state_t                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   hold_idat_q, hold_idat_d, hold_qdat_q, hold_qdat_d;
  logic [7:0]                     hold_cnt_q, hold_cnt_d;
  logic [NCO_WIDTH-1:0]           acc_q, acc_d;
  logic                           s1_valid_q, s1_valid_d;
  logic signed [DATA_WIDTH-1:0]   s1_idat_q, s1_idat_d, s1_qdat_q, s1_qdat_d;
  logic [7:0]                     s1_idx_q, s1_idx_d;
  logic                           s2_valid_q, s2_valid_d;
  logic signed [DATA_WIDTH-1:0]   s2_idat_q, s2_idat_d, s2_qdat_q, s2_qdat_d;
  logic signed [15:0]             s2_sin_q, s2_sin_d, s2_cos_q, s2_cos_d;
  logic                           dac_valid_q, dac_valid_d;
  logic [DAC_WIDTH-1:0]           dac_data_q, dac_data_d;
  logic                           sat_q, sat_d;
  logic [15:0]                    uflow_q, uflow_d;

  logic                           adv, last_emit, xfer;
  logic [7:0]                     interp_eff, phase_idx;
  logic signed [PW-1:0]           i_ext, q_ext, c_ext, s_ext, mac, mixed;
  logic [DAC_WIDTH-1:0]           sat_val;
  logic                           clip;

  always_comb begin
    adv        = !dac_valid_q || dac_ready;
    last_emit  = (state_q == HOLD) && (hold_cnt_q == 8'd1);
    in_ready   = enable && rst_n && ((state_q == IDLE) || (last_emit && adv));
    xfer       = in_valid && in_ready;
    interp_eff = (interp == 8'd0) ? 8'd1 : interp;
    phase_idx  = 8'((acc_q[NCO_WIDTH-1 -: 16] + nco_phase_offset) >> 8);
  end

  // Full-precision I*cos - Q*sin, floor shift by 15, clip to the DAC range.
  always_comb begin
    i_ext = {{(PW-DATA_WIDTH){s2_idat_q[DATA_WIDTH-1]}}, s2_idat_q};
    q_ext = {{(PW-DATA_WIDTH){s2_qdat_q[DATA_WIDTH-1]}}, s2_qdat_q};
    c_ext = {{(PW-16){s2_cos_q[15]}}, s2_cos_q};
    s_ext = {{(PW-16){s2_sin_q[15]}}, s2_sin_q};
    mac   = i_ext * c_ext - q_ext * s_ext;
    mixed = mac >>> 15;
    clip  = 1'b1;
    if (mixed > DAC_MAX) begin
      sat_val = {1'b0, {(DAC_WIDTH-1){1'b1}}};
    end else if (mixed < DAC_MIN) begin
      sat_val = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    end else begin
      sat_val = mixed[DAC_WIDTH-1:0];
      clip    = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_idat_d = hold_idat_q;
    hold_qdat_d = hold_qdat_q;
    hold_cnt_d  = hold_cnt_q;
    acc_d       = acc_q;
    s1_valid_d  = s1_valid_q;
    s1_idat_d   = s1_idat_q;
    s1_qdat_d   = s1_qdat_q;
    s1_idx_d    = s1_idx_q;
    s2_valid_d  = s2_valid_q;
    s2_idat_d   = s2_idat_q;
    s2_qdat_d   = s2_qdat_q;
    s2_sin_d    = s2_sin_q;
    s2_cos_d    = s2_cos_q;
    dac_valid_d = dac_valid_q;
    dac_data_d  = dac_data_q;
    sat_d       = sat_q;
    uflow_d     = uflow_q;

    if (xfer) begin
      hold_idat_d = i_data_in;
      hold_qdat_d = q_data_in;
      hold_cnt_d  = interp_eff;
      state_d     = HOLD;
    end

    // A back-to-back transfer on the last emission reloads the hold without a gap cycle.
    if ((state_q == HOLD) && adv) begin
      acc_d = acc_q + nco_freq;
      if (!last_emit) begin
        hold_cnt_d = hold_cnt_q - 8'd1;
      end else if (!xfer) begin
        state_d    = IDLE;
        hold_cnt_d = 8'd0;
        if (enable && (uflow_q != 16'hFFFF)) begin
          uflow_d = uflow_q + 16'd1;
        end
      end
    end

    if (adv) begin
      s1_valid_d  = (state_q == HOLD);
      s1_idat_d   = hold_idat_q;
      s1_qdat_d   = hold_qdat_q;
      s1_idx_d    = phase_idx;
      s2_valid_d  = s1_valid_q;
      s2_idat_d   = s1_idat_q;
      s2_qdat_d   = s1_qdat_q;
      s2_sin_d    = sin_lut(s1_idx_q);
      s2_cos_d    = sin_lut(s1_idx_q + 8'd64);
      dac_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        dac_data_d = sat_val;
        sat_d      = sat_q | clip;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_idat_q <= '0;
      hold_qdat_q <= '0;
      hold_cnt_q  <= '0;
      acc_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_idat_q   <= '0;
      s1_qdat_q   <= '0;
      s1_idx_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_idat_q   <= '0;
      s2_qdat_q   <= '0;
      s2_sin_q    <= '0;
      s2_cos_q    <= '0;
      dac_valid_q <= 1'b0;
      dac_data_q  <= '0;
      sat_q       <= 1'b0;
      uflow_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_idat_q <= hold_idat_d;
      hold_qdat_q <= hold_qdat_d;
      hold_cnt_q  <= hold_cnt_d;
      acc_q       <= acc_d;
      s1_valid_q  <= s1_valid_d;
      s1_idat_q   <= s1_idat_d;
      s1_qdat_q   <= s1_qdat_d;
      s1_idx_q    <= s1_idx_d;
      s2_valid_q  <= s2_valid_d;
      s2_idat_q   <= s2_idat_d;
      s2_qdat_q   <= s2_qdat_d;
      s2_sin_q    <= s2_sin_d;
      s2_cos_q    <= s2_cos_d;
      dac_valid_q <= dac_valid_d;
      dac_data_q  <= dac_data_d;
      sat_q       <= sat_d;
      uflow_q     <= uflow_d;
    end
  end

  assign dac_data        = dac_data_q;
  assign dac_valid       = dac_valid_q;
  assign sat_flag        = sat_q;
  assign underflow_count = uflow_q;
  assign busy            = (state_q != IDLE) || s1_valid_q || s2_valid_q || dac_valid_q;

endmodule

// File: tb/tb_duc_tx_core.sv
// tb/tb_duc_tx_core.sv - directed checks of duc_tx_core: reset, mixing, hold, backpressure, saturation
// Vectors use nco_freq=0 so every emission of a sample carries the same expected value.
module tb_duc_tx_core;

  logic               clk = 1'b0;
  logic               rst_n, enable, in_valid, in_ready, dac_valid, dac_ready, sat_flag, busy;
  logic [7:0]         interp;
  logic [23:0]        nco_freq;
  logic [15:0]        nco_phase_offset, underflow_count;
  logic signed [17:0] i_data_in, q_data_in;
  logic signed [15:0] dac_data;

  duc_tx_core dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .interp(interp), .nco_freq(nco_freq),
    .nco_phase_offset(nco_phase_offset), .i_data_in(i_data_in), .q_data_in(q_data_in),
    .in_valid(in_valid), .in_ready(in_ready), .dac_data(dac_data), .dac_valid(dac_valid),
    .dac_ready(dac_ready), .underflow_count(underflow_count), .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]         interp;
    logic [15:0]        off;
    logic signed [17:0] i;
    logic signed [17:0] q;
    int                 n_exp;
    logic signed [15:0] exp;
    logic               sat;
  } vec_t;

  vec_t        vt[11];
  int          samp[4];
  int          cosv[4];
  longint      expv[12];
  int          first, nout, uf, sent, got, stall_bad, stalls_seen, rdy, seen, guard;
  logic        stall_prev, x, o;
  logic signed [15:0] held, od;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{8'd4, 16'h0000, 18'sd16384,   18'sd0,       4, 16'sd16383,  1'b0};
    vt[1]  = '{8'd1, 16'h4000, 18'sd0,       18'sd16384,   1, -16'sd16384, 1'b0};
    vt[2]  = '{8'd0, 16'h0000, -18'sd16384,  18'sd0,       1, -16'sd16384, 1'b0};
    vt[3]  = '{8'd2, 16'h8000, 18'sd1000,    18'sd500,     2, -16'sd1000,  1'b0};
    vt[4]  = '{8'd3, 16'hC000, 18'sd7,       18'sd100,     3, 16'sd99,     1'b0};
    vt[5]  = '{8'd1, 16'h2000, 18'sd1000,    18'sd1000,    1, 16'sd0,      1'b0};
    vt[6]  = '{8'd5, 16'h40FF, 18'sd0,       18'sd16384,   5, -16'sd16384, 1'b0};
    vt[7]  = '{8'd1, 16'hFF00, 18'sd1000,    18'sd16384,   1, 16'sd1401,   1'b0};
    vt[8]  = '{8'd1, 16'h0100, 18'sd0,       -18'sd32768,  1, 16'sd804,    1'b0};
    vt[9]  = '{8'd1, 16'h0000, 18'h20000,    18'sd0,       1, 16'sh8000,   1'b1};
    vt[10] = '{8'd2, 16'h2000, 18'sd131071,  -18'sd131071, 2, 16'sd32767,  1'b1};

    rst_n = 1'b0; enable = 1'b1; interp = 8'd1; nco_freq = '0; nco_phase_offset = '0;
    i_data_in = 18'sd5; q_data_in = 18'sd5; in_valid = 1'b1; dac_ready = 1'b1;
    repeat (10) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dac_valid", dac_valid, 0);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_uflow", underflow_count, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_busy", busy, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    uf = 0;
    for (int v = 0; v < 11; v++) begin
      interp = vt[v].interp; nco_phase_offset = vt[v].off;
      i_data_in = vt[v].i; q_data_in = vt[v].q; in_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", v), in_ready, 1);
      tick();
      in_valid = 1'b0;
      interp = 8'd7;
      first = -1;
      nout = 0;
      for (int c = 1; c <= vt[v].n_exp + 6; c++) begin
        tick();
        if (dac_valid === 1'b1) begin
          if (first < 0) first = c;
          nout++;
          chk($sformatf("vec%0d_data", v), dac_data, vt[v].exp);
        end
      end
      uf++;
      chk($sformatf("vec%0d_latency", v), first, 3);
      chk($sformatf("vec%0d_count", v), nout, vt[v].n_exp);
      chk($sformatf("vec%0d_sat", v), sat_flag, vt[v].sat);
      chk($sformatf("vec%0d_uflow", v), underflow_count, uf);
      chk($sformatf("vec%0d_busy", v), busy, 0);
    end

    // Backpressure: four samples, interp=3, NCO steps a quarter turn per emission.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    nco_freq = 24'h400000; nco_phase_offset = 16'h0000; interp = 8'd3; q_data_in = 18'sd0;
    samp = '{16384, 8192, 4096, 2048};
    cosv = '{32767, 0, -32767, 0};
    for (int e = 0; e < 12; e++) expv[e] = (longint'(samp[e / 3]) * cosv[e % 4]) >>> 15;
    sent = 0; got = 0; stall_bad = 0; stalls_seen = 0; stall_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      dac_ready = !(cyc >= 8 && cyc < 13);
      in_valid  = (sent < 4);
      i_data_in = 18'(samp[(sent < 4) ? sent : 0]);
      #3;
      if (stall_prev && (dac_valid !== 1'b1 || dac_data !== held)) stall_bad++;
      x  = in_valid && in_ready;
      o  = dac_valid && dac_ready;
      od = dac_data;
      stall_prev = dac_valid && !dac_ready;
      held = dac_data;
      if (stall_prev) stalls_seen++;
      tick();
      if (x) sent++;
      if (o) begin
        if (got < 12) chk($sformatf("bp_data%0d", got), od, expv[got]);
        got++;
      end
    end
    in_valid = 1'b0;
    dac_ready = 1'b1;
    chk("bp_count", got, 12);
    chk("bp_stall_hold", stall_bad, 0);
    chk("bp_stall_cycles", stalls_seen, 5);
    chk("bp_uflow", underflow_count, 1);

    // enable=0 blocks new transfers but lets the current hold finish without an underflow.
    nco_freq = '0; interp = 8'd2; i_data_in = 18'sd16384; q_data_in = 18'sd0; in_valid = 1'b1;
    tick();
    enable = 1'b0;
    i_data_in = 18'sd8192;
    nout = 0; rdy = 0;
    for (int c = 1; c <= 10; c++) begin
      if (in_ready) rdy++;
      tick();
      if (dac_valid === 1'b1) begin
        nout++;
        chk("en_data", dac_data, 16383);
      end
    end
    chk("en_count", nout, 2);
    chk("en_ready_seen", rdy, 0);
    chk("en_uflow", underflow_count, 1);
    chk("en_busy", busy, 0);
    in_valid = 1'b0;
    enable = 1'b1;

    // Reset during a long hold, then the next sample must start from phase zero.
    nco_freq = 24'h400000; interp = 8'd8; i_data_in = 18'sd16384; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 0; guard = 0;
    while (seen < 3 && guard < 20) begin
      tick();
      guard++;
      if (dac_valid === 1'b1) seen++;
    end
    chk("mh_seen", seen, 3);
    rst_n = 1'b0;
    tick();
    chk("mh_dac_valid", dac_valid, 0);
    chk("mh_busy", busy, 0);
    chk("mh_uflow", underflow_count, 0);
    rst_n = 1'b1;
    interp = 8'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("mh_early_valid", dac_valid, 0);
    tick();
    chk("mh_valid", dac_valid, 1);
    chk("mh_acc0_data", dac_data, 16383);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
